// File: rtl/sva_within_sequencer_if.sv
// Event/verdict bundle for sva_within_sequencer.
// Ports: outer_start/outer_end/inner_start/inner_end in; busy, pass, fail,
//        fail_code, win_len, pass_cnt, fail_cnt out (slave view).
interface sva_within_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             outer_start;
    logic             outer_end;
    logic             inner_start;
    logic             inner_end;
    logic             busy;
    logic             pass;
    logic             fail;
    logic [1:0]       fail_code;
    logic [CNT_W-1:0] win_len;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;

    modport master (
        output outer_start, outer_end, inner_start, inner_end,
        input  busy, pass, fail, fail_code, win_len, pass_cnt, fail_cnt
    );

    modport slave (
        input  outer_start, outer_end, inner_start, inner_end,
        output busy, pass, fail, fail_code, win_len, pass_cnt, fail_cnt
    );
endinterface

// File: rtl/sva_within_sequencer.sv
// Checks `inner within (outer_start ##[1:$] outer_end)` for one window at a time.
// Latency: verdict (pass/fail + fail_code + win_len) registered, visible the cycle after outer_end.
// Backpressure: none; pure observer, events are sampled every cycle and never stalled.
// Ports: i_clk, i_rst_n (async active-low), bus (sva_within_sequencer_if.slave).
// Optional macro SVA_WITHIN_TIMEOUT_EN: closes a window with fail code 3 once it
// reaches MAX_WINDOW cycles without outer_end.
module sva_within_sequencer #(
    parameter int CNT_W      = 16,
    parameter int MAX_WINDOW = 1000
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    sva_within_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OUTER = 2'd1,
        S_INNER = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] CODE_NONE     = 2'd0;
    localparam logic [1:0] CODE_NO_INNER = 2'd1;
    localparam logic [1:0] CODE_OVERRUN  = 2'd2;
    localparam logic [1:0] CODE_TIMEOUT  = 2'd3;

    state_t           r_state;
    state_t           w_state_nxt;
    state_t           w_state_eff;   // state after this cycle's inner events, before close
    logic [CNT_W-1:0] r_cnt;         // window cycles elapsed before the current one
    logic [CNT_W-1:0] w_len;         // inclusive window length if it closed this cycle
    logic             w_close;
    logic             w_timeout;
    logic             w_pass;
    logic             w_fail;
    logic [1:0]       w_code;

    logic             r_pass;
    logic             r_fail;
    logic [1:0]       r_code;
    logic [CNT_W-1:0] r_win_len;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;

    assign w_len   = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    // The start cycle is spent in IDLE, so outer_end there is naturally ignored.
    assign w_close = (r_state != S_IDLE) && bus.outer_end;

`ifdef SVA_WITHIN_TIMEOUT_EN
    // outer_end landing in the limit cycle wins over the timeout.
    assign w_timeout = (r_state != S_IDLE) && !bus.outer_end &&
                       (w_len == CNT_W'(MAX_WINDOW));
`else
    logic [31:0] w_unused_max_window;
    assign w_unused_max_window = MAX_WINDOW;
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_eff = r_state;
        w_state_nxt = r_state;
        w_pass      = 1'b0;
        w_fail      = 1'b0;
        w_code      = CODE_NONE;

        // Inner events are folded in first so a same-cycle close sees them.
        case (r_state)
            S_OUTER: begin
                if (bus.inner_start && bus.inner_end) begin
                    w_state_eff = S_DONE;
                end else if (bus.inner_start) begin
                    w_state_eff = S_INNER;
                end
            end
            S_INNER: begin
                if (bus.inner_end) begin
                    w_state_eff = S_DONE;
                end
            end
            default: w_state_eff = r_state;
        endcase

        if (r_state == S_IDLE) begin
            if (bus.outer_start) begin
                if (bus.inner_start && bus.inner_end) begin
                    w_state_nxt = S_DONE;
                end else if (bus.inner_start) begin
                    w_state_nxt = S_INNER;
                end else begin
                    w_state_nxt = S_OUTER;
                end
            end
        end else if (w_close) begin
            // outer_start coinciding with the close is dropped: we go to IDLE.
            w_state_nxt = S_IDLE;
            if (w_state_eff == S_DONE) begin
                w_pass = 1'b1;
            end else begin
                w_fail = 1'b1;
                w_code = (w_state_eff == S_INNER) ? CODE_OVERRUN : CODE_NO_INNER;
            end
        end else if (w_timeout) begin
            w_state_nxt = S_IDLE;
            w_fail      = 1'b1;
            w_code      = CODE_TIMEOUT;
        end else begin
            w_state_nxt = w_state_eff;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_pass     <= 1'b0;
            r_fail     <= 1'b0;
            r_code     <= CODE_NONE;
            r_win_len  <= '0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
        end else begin
            r_pass <= w_pass;
            r_fail <= w_fail;
            r_code <= w_code;

            if (r_state == S_IDLE) begin
                if (bus.outer_start) begin
                    r_cnt <= CNT_W'(1);
                end
            end else if (w_pass || w_fail) begin
                r_cnt <= '0;
            end else if (!(&r_cnt)) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_pass || w_fail) begin
                r_win_len <= w_len;
            end
            if (w_pass && !(&r_pass_cnt)) begin
                r_pass_cnt <= r_pass_cnt + 1'b1;
            end
            if (w_fail && !(&r_fail_cnt)) begin
                r_fail_cnt <= r_fail_cnt + 1'b1;
            end
        end
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.pass      = r_pass;
    assign bus.fail      = r_fail;
    assign bus.fail_code = r_code;
    assign bus.win_len   = r_win_len;
    assign bus.pass_cnt  = r_pass_cnt;
    assign bus.fail_cnt  = r_fail_cnt;

endmodule

// File: doc/sva_within_sequencer.md
Name: sva_within_sequencer

Overview:
- Runtime hardware checker that sequences one SVA-style `within` evaluation: `inner within (outer_start ##[1:$] outer_end)`.
- Tracks one outer window and one inner sequence. Emits a pass or fail verdict when the outer window closes.
- Sits beside the assertion datapath in the regression harness. Aggregates verdict counts for the bench scoreboard.

Parameters:
- CNT_W, 16, width of window-length counter and of pass/fail counters.
- MAX_WINDOW, 1000, outer window cycle limit. Used only with timeout feature.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- outer_start  in  1  outer window open event.
- outer_end  in  1  outer window close event.
- inner_start  in  1  inner sequence begin event.
- inner_end  in  1  inner sequence end event.
- busy  out  1  outer window open.
- pass  out  1  one-cycle verdict pulse: inner fully contained.
- fail  out  1  one-cycle verdict pulse: containment violated.
- fail_code  out  2  0 none, 1 no inner, 2 inner overran, 3 timeout; valid with fail.
- win_len  out  CNT_W  length of last closed window in cycles, start and end inclusive.
- pass_cnt  out  CNT_W  saturating pass count.
- fail_cnt  out  CNT_W  saturating fail count.

Behaviour:
- Reset, async on rst_n low: state IDLE. busy, pass, fail, fail_code, win_len, pass_cnt, fail_cnt all 0. Reset mid-window discards the window with no verdict.
- States: IDLE, OUTER (window open, inner not started), INNER (inner open), DONE (inner completed, waiting outer_end).
- IDLE:
  - outer_start -> OUTER. Internal cycle counter = 1.
  - If inner_start is also high in that cycle -> INNER.
  - If inner_start and inner_end are both high in that cycle -> DONE.
  - outer_end in the start cycle is ignored, because ##[1:$] needs at least 1 cycle gap.
  - inner_* in IDLE is ignored.
- OUTER:
  - inner_start -> INNER.
  - inner_start & inner_end in the same cycle -> DONE.
  - If outer_end is also high that cycle, the inner events win first, then the close is evaluated in the same cycle.
- INNER: inner_end -> DONE. Further inner_start is ignored.
- DONE: further inner events are ignored. Only the first inner match is evaluated.
- Window close: outer_end while busy and not in the start cycle -> IDLE. The verdict is registered and visible the cycle after outer_end (latency 1):
  - DONE, or inner_end in the same cycle as outer_end -> pass.
  - OUTER with no inner_start -> fail, code 1.
  - INNER with no inner_end -> fail, code 2.
- outer_start while busy is ignored; windows never overlap.
- outer_start in the same cycle as the verdict-producing outer_end is ignored. The next window needs a fresh outer_start.
- win_len is updated with each verdict. It saturates at all-ones.
- pass_cnt and fail_cnt increment with their pulse and hold at all-ones.
- busy is high from the cycle after outer_start through the cycle of outer_end.

Optional Feature:
- Macro SVA_WITHIN_TIMEOUT_EN.
- Defined:
  - When the window counter reaches MAX_WINDOW with no outer_end, the block issues fail with code 3 next cycle, returns to IDLE and drops busy.
  - An outer_end arriving in the MAX_WINDOW cycle takes priority over the timeout.
- Undefined:
  - No timeout; the window stays open indefinitely.
  - Code 3 is never produced.
  - MAX_WINDOW is unused.

Test Plan:
- Containment: outer_start@10, outer_end@20, inner_start@12, inner_end@18 -> pass pulse @21, win_len=11, pass_cnt=1, busy high 11..20.
- No inner: outer_start@5, outer_end@9, inner idle -> fail @10, fail_code=1, fail_cnt=1.
- Overrun: outer_start@3, inner_start@4, outer_end@6, inner_end@8 -> fail @7, code 2. The inner_end @8 is ignored (IDLE).
- Edge coincidence: outer_start, inner_start and inner_end all @2, outer_end@2 ignored, outer_end@3 -> pass @4, win_len=2.
- Reset mid-window: outer_start@4, rst_n low @6..7 -> all outputs 0, no verdict. Next outer_start@10/outer_end@12 with no inner -> fail code 1.
- Timeout, with SVA_WITHIN_TIMEOUT_EN and MAX_WINDOW=8: outer_start@0, no end -> fail code 3 @8, busy=0 @8.
